mult_pipe: RTL and testbench

Parametrised pipelined multiply / multiply-accumulate unit with valid/ready flow control. It generalises the fixed 8-bit, two-register multiplier in three ways:
- configurable operand width and pipeline depth;
- per-transaction signed/unsigned selection;
- optional accumulation into a wide, wrapping accumulator.

It sits between a streaming operand source and a result sink, either of which may stall.

---
 rtl/mult_pipe.sv | 135 +++++++++++++
 tb/tb_mult_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined signed/unsigned multiply / multiply-accumulate unit
// with valid/ready flow control and a wrapping accumulator.
module mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int ACC_W  = 2*WIDTH+4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_signed,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] y
);

    localparam int PW = 2*WIDTH;
    localparam int D  = STAGES-2;

    logic             adv;
    logic [WIDTH-1:0] a_q, b_q;
    logic             s1_q, c1_q, v1_q;
    logic [PW-1:0]    ax, bx, prod;

    logic [PW-1:0]    pl_p;
    logic             pl_s, pl_c, pl_v;

    logic [ACC_W-1:0] ext, sum;
    logic [ACC_W-1:0] y_q, y_d, acc_q, acc_d;
    logic             ov_q, ov_d;

    // One global stall: nothing moves while a result waits on the sink.
    assign adv       = !ov_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = ov_q;
    assign y         = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            s1_q <= 1'b0;
            c1_q <= 1'b0;
            v1_q <= 1'b0;
        end else if (adv) begin
            a_q  <= a;
            b_q  <= b;
            s1_q <= in_signed;
            c1_q <= in_acc;
            v1_q <= in_valid;
        end
    end

    // Extending both operands to 2W bits makes a truncated 2W multiply
    // exact for both signed and unsigned operands.
    always_comb begin
        ax   = {{WIDTH{s1_q & a_q[WIDTH-1]}}, a_q};
        bx   = {{WIDTH{s1_q & b_q[WIDTH-1]}}, b_q};
        prod = ax * bx;
    end

    generate
        if (D > 0) begin : g_delay
            logic [PW-1:0] p_q [D];
            logic [D-1:0]  s_q, c_q, v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        p_q[i] <= '0;
                    end
                    s_q <= '0;
                    c_q <= '0;
                    v_q <= '0;
                end else if (adv) begin
                    p_q[0] <= prod;
                    s_q[0] <= s1_q;
                    c_q[0] <= c1_q;
                    v_q[0] <= v1_q;
                    for (int i = 1; i < D; i++) begin
                        p_q[i] <= p_q[i-1];
                        s_q[i] <= s_q[i-1];
                        c_q[i] <= c_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            assign pl_p = p_q[D-1];
            assign pl_s = s_q[D-1];
            assign pl_c = c_q[D-1];
            assign pl_v = v_q[D-1];
        end else begin : g_direct
            assign pl_p = prod;
            assign pl_s = s1_q;
            assign pl_c = c1_q;
            assign pl_v = v1_q;
        end
    endgenerate

    always_comb begin
        ext = pl_s ? ACC_W'($signed(pl_p)) : ACC_W'(pl_p);
        sum = pl_c ? acc_q + ext : ext;
    end

    always_comb begin
        y_d   = y_q;
        acc_d = acc_q;
        ov_d  = ov_q;
        if (adv) begin
            ov_d = pl_v;
            if (pl_v) begin
                y_d   = sum;
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            acc_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            y_q   <= y_d;
            acc_q <= acc_d;
            ov_q  <= ov_d;
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: scoreboard bench for mult_pipe (WIDTH=8, STAGES=3,
// ACC_W=20) with directed cases and randomized streaming.
module tb_mult_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int ACC_W  = 20;
    localparam longint MASK = (longint'(1) << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             in_signed, in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] y;

    int     checks = 0;
    int     errors = 0;
    longint expq[$];
    longint accm = 0;
    bit     stall_prev = 1'b0;
    logic [ACC_W-1:0] y_prev = '0;
    bit     rnd_done;

    mult_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .in_signed(in_signed),
        .in_acc   (in_acc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Output monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %0d expected none at %0t",
                         y, $time);
            end else begin
                longint e;
                e = expq.pop_front();
                checks--;
                check("result", longint'(y), e);
            end
        end
    end

    // Flow-control monitor: in_ready and y stability during stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", longint'(in_ready),
                  longint'(!(out_valid && !out_ready)));
            if (stall_prev)
                check("y_hold", longint'(y), longint'(y_prev));
            stall_prev = out_valid && !out_ready;
            y_prev     = y;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic longint sx(input int v, input bit s);
        return (s && v >= 128) ? longint'(v - 256) : longint'(v);
    endfunction

    task automatic send(input int av, input int bv, input bit s,
                        input bit c, input longint exp, input bit use_exp);
        longint p, r;
        int n;
        a = av[7:0];
        b = bv[7:0];
        in_signed = s;
        in_acc = c;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no in_ready expected accept");
                in_valid = 1'b0;
                return;
            end
        end
        p = sx(av, s) * sx(bv, s);
        r = (c ? accm + p : p) & MASK;
        accm = r;
        expq.push_back(use_exp ? exp : r);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", longint'(expq.size()), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_signed = 1'b0;
        in_acc    = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y", longint'(y), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned max with latency check
        send(255, 255, 0, 0, 65025, 1);
        check("lat_e0", longint'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_e1", longint'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_e2", longint'(out_valid), 1);
        check("lat_y", longint'(y), 65025);
        @(posedge clk); #1;
        check("lat_e3", longint'(out_valid), 0);
        drain();

        // Signed
        send(128, 128, 1, 0, 16384, 1);
        send(255, 1, 1, 0, 20'hFFFFF, 1);
        send(255, 1, 0, 0, 255, 1);
        drain();

        // Accumulate chain
        send(3, 4, 0, 0, 12, 1);
        send(5, 6, 0, 1, 42, 1);
        send(2, 2, 0, 1, 46, 1);
        send(7, 1, 0, 0, 7, 1);
        drain();

        // Backpressure
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(i, 2, 0, 0, longint'(2*i), 1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Wrap
        send(255, 255, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++)
            send(255, 255, 0, 1, 0, 0);
        send(255, 255, 0, 1, 56849, 1);
        drain();

        // Reset mid-flight
        send(9, 9, 0, 0, 81, 1);
        send(3, 3, 0, 1, 90, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_y", longint'(y), 0);
        check("mid_rst_in_ready", longint'(in_ready), 1);
        expq.delete();
        accm = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, 3, 0, 1, 6, 1);
        drain();
        repeat (10) @(posedge clk);
        #1;

        // Randomized streaming with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)),
                         bit'($urandom_range(0, 1)),
                         bit'($urandom_range(0, 1)), 0, 0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        check("queue_empty", longint'(expq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
